// File: rtl/udp_rx_scheduler.sv
// udp_rx_scheduler: shares one UDP_decoder between two IP-layer receive queues.
// Each packet is granted round-robin, length-checked, the decoder is reset, the
// payload words are streamed one per cycle, and a one-cycle status pulse goes
// back to the owning queue.
module udp_rx_scheduler #(
  parameter logic [15:0] MAX_UDP_LEN    = 16'd1480,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [63:0] src_ip_in,
  input  logic [63:0] dest_ip_in,
  input  logic [31:0] len_udp_in,
  input  logic [63:0] s_data,
  input  logic [1:0]  s_valid,
  output logic [1:0]  gnt,
  output logic [1:0]  rd,
  output logic        pkt_done,
  output logic        pkt_src,
  output logic [1:0]  pkt_status,
  output logic        busy,
  output logic        dec_reset,
  output logic        dec_start,
  output logic [31:0] dec_data,
  output logic [31:0] dec_src_ip,
  output logic [31:0] dec_dest_ip,
  output logic [15:0] dec_len_udp,
  input  logic        dec_ok,
  input  logic        dec_fin
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_CHKS_BAD = 2'b01;
  localparam logic [1:0] ST_LEN_BAD  = 2'b10;
  localparam logic [1:0] ST_ABORT    = 2'b11;

  typedef enum logic [2:0] {IDLE, CHECK, DRST, STREAM, WAIT_FIN, DONE} state_e;

  state_e        state_q;
  logic          g_q;
  logic          lastGnt_q;
  logic [1:0]    gnt_q;
  logic [1:0]    status_q;
  logic [31:0]   srcIp_q;
  logic [31:0]   destIp_q;
  logic [15:0]   len_q;
  logic [14:0]   words_q;
  logic [14:0]   k_q;
  logic [TW-1:0] tcnt_q;
  logic          finSeen_q;
  logic          okSeen_q;

  logic          sel_d;
  logic [TW-1:0] tcnt_d;
  logic [16:0]   wordsSum;
  logic [31:0]   curWord;
  logic          wordValid;
  logic          lastWord;

  // Pick the next owner: a lone requester wins, a tie goes to the queue not served last.
  always_comb begin
    sel_d = (req == 2'b11) ? ~lastGnt_q : req[1];
  end

  // Word path from the granted queue to the decoder, plus the counters' next values.
  always_comb begin
    curWord   = g_q ? s_data[63:32] : s_data[31:0];
    wordValid = (state_q == STREAM) && s_valid[g_q];
    lastWord  = (k_q == words_q - 15'd1);
    tcnt_d    = tcnt_q + TW'(1);
    wordsSum  = {1'b0, len_q} + 17'd3;
  end

  assign gnt         = gnt_q;
  assign rd          = wordValid ? {g_q, ~g_q} : 2'b00;
  assign dec_data    = wordValid ? curWord : 32'd0;
  assign dec_start   = wordValid && (k_q == 15'd0);
  assign pkt_done    = (state_q == DONE);
  assign pkt_src     = g_q;
  assign pkt_status  = status_q;
  assign busy        = (state_q != IDLE);
  assign dec_reset   = reset || (state_q == DRST) || ((state_q == DONE) && (status_q == ST_ABORT));
  assign dec_src_ip  = srcIp_q;
  assign dec_dest_ip = destIp_q;
  assign dec_len_udp = len_q;

  // Packet sequencer: grant, length check, decoder reset, stream, wait for fin, report.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= 1'b0;
      lastGnt_q <= 1'b1;
      gnt_q     <= 2'b00;
      status_q  <= ST_OK;
      srcIp_q   <= 32'd0;
      destIp_q  <= 32'd0;
      len_q     <= 16'd0;
      words_q   <= 15'd0;
      k_q       <= 15'd0;
      tcnt_q    <= '0;
      finSeen_q <= 1'b0;
      okSeen_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            g_q      <= sel_d;
            gnt_q    <= {sel_d, ~sel_d};
            srcIp_q  <= sel_d ? src_ip_in[63:32]  : src_ip_in[31:0];
            destIp_q <= sel_d ? dest_ip_in[63:32] : dest_ip_in[31:0];
            len_q    <= sel_d ? len_udp_in[31:16] : len_udp_in[15:0];
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          if ((len_q < 16'd8) || (len_q > MAX_UDP_LEN)) begin
            status_q <= ST_LEN_BAD;
            state_q  <= DONE;
          end else begin
            words_q <= 15'(wordsSum >> 2);
            state_q <= DRST;
          end
        end
        DRST: begin
          k_q       <= 15'd0;
          tcnt_q    <= '0;
          finSeen_q <= 1'b0;
          okSeen_q  <= 1'b0;
          state_q   <= STREAM;
        end
        STREAM: begin
          if (dec_fin && !finSeen_q) begin
            finSeen_q <= 1'b1;
            okSeen_q  <= dec_ok;
          end
          if (!s_valid[g_q]) begin
            status_q <= ST_ABORT;
            state_q  <= DONE;
          end else begin
            k_q <= k_q + 15'd1;
            if (lastWord) begin
              if (finSeen_q) begin
                status_q <= okSeen_q ? ST_OK : ST_CHKS_BAD;
                state_q  <= DONE;
              end else if (dec_fin) begin
                status_q <= dec_ok ? ST_OK : ST_CHKS_BAD;
                state_q  <= DONE;
              end else begin
                state_q <= WAIT_FIN;
              end
            end
          end
        end
        WAIT_FIN: begin
          tcnt_q <= tcnt_d;
          if (dec_fin) begin
            status_q <= dec_ok ? ST_OK : ST_CHKS_BAD;
            state_q  <= DONE;
          end else if (tcnt_d == TW'(TIMEOUT_CYCLES)) begin
            status_q <= ST_ABORT;
            state_q  <= DONE;
          end
        end
        DONE: begin
          lastGnt_q <= g_q;
          gnt_q     <= 2'b00;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_scheduler.sv
// Testbench for udp_rx_scheduler: emulates both receive queues and the decoder,
// predicts each packet's timeline from its length, stall point and fin timing,
// and compares every output on every cycle.
module tb_udp_rx_scheduler;

  localparam int TIMEOUT = 64;
  localparam int MAXLEN  = 1480;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [63:0] src_ip_in;
  logic [63:0] dest_ip_in;
  logic [31:0] len_udp_in;
  logic [63:0] s_data;
  logic [1:0]  s_valid;
  logic [1:0]  gnt;
  logic [1:0]  rd;
  logic        pkt_done;
  logic        pkt_src;
  logic [1:0]  pkt_status;
  logic        busy;
  logic        dec_reset;
  logic        dec_start;
  logic [31:0] dec_data;
  logic [31:0] dec_src_ip;
  logic [31:0] dec_dest_ip;
  logic [15:0] dec_len_udp;
  logic        dec_ok;
  logic        dec_fin;

  always #5 clk = ~clk;

  udp_rx_scheduler #(.MAX_UDP_LEN(16'd1480), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req),
    .src_ip_in(src_ip_in), .dest_ip_in(dest_ip_in), .len_udp_in(len_udp_in),
    .s_data(s_data), .s_valid(s_valid),
    .gnt(gnt), .rd(rd), .pkt_done(pkt_done), .pkt_src(pkt_src), .pkt_status(pkt_status),
    .busy(busy), .dec_reset(dec_reset), .dec_start(dec_start), .dec_data(dec_data),
    .dec_src_ip(dec_src_ip), .dec_dest_ip(dec_dest_ip), .dec_len_udp(dec_len_udp),
    .dec_ok(dec_ok), .dec_fin(dec_fin)
  );

  // A queued packet: stall = word index at which the queue runs dry (-1 none),
  // finT = cycle offset from the arbitration cycle where the decoder raises fin (-1 never).
  typedef struct {
    logic [15:0] len;
    logic [31:0] sip;
    logic [31:0] dip;
    int          stall;
    int          finT;
    bit          ok;
    bit          hello;
  } pkt_t;

  pkt_t pq0[$];
  pkt_t pq1[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit         mActive = 1'b0;
  bit         mG      = 1'b0;
  bit         mLastG  = 1'b1;
  bit         mLenBad = 1'b0;
  int         mT      = 0;
  int         mW      = 0;
  int         mDoneT  = 0;
  logic [1:0] mStatus = 2'b00;
  logic [1:0] mRdExp  = 2'b00;
  pkt_t       mPkt;
  int         popped[2];

  int         obsRd, obsRst, obsReqT, obsStartT, obsDoneT;
  logic [31:0] obsSrcIp;
  int         srcLog[$];
  int         statusLog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic pkt_t mkPkt(input int len, input logic [31:0] sip, input logic [31:0] dip,
                                 input int stall, input int finT, input bit ok, input bit hello);
    pkt_t p;
    p.len = 16'(len); p.sip = sip; p.dip = dip;
    p.stall = stall; p.finT = finT; p.ok = ok; p.hello = hello;
    return p;
  endfunction

  function automatic int wordsOf(input logic [15:0] len);
    return (int'(len) + 3) / 4;
  endfunction

  function automatic logic [31:0] wordOf(input pkt_t p, input int j);
    logic [31:0] hw [5];
    hw = '{32'h04d2162e, 32'h0013a1b2, 32'h48656c6c, 32'h6f20576f, 32'h726c6400};
    if (p.hello && j < 5) return hw[j];
    return p.sip ^ (32'(j) * 32'h9e3779b9);
  endfunction

  function automatic bit pending(input int i);
    return (i == 0) ? (pq0.size() > 0) : (pq1.size() > 0);
  endfunction

  function automatic pkt_t headPkt(input int i);
    if (i == 0) return pq0[0];
    return pq1[0];
  endfunction

  // Work out when the packet finishes and with what status, straight from the protocol rules.
  task automatic startPacket();
    bit p0, p1;
    p0 = pending(0);
    p1 = pending(1);
    mG = (p0 && p1) ? !mLastG : p1;
    mPkt = headPkt(int'(mG));
    mActive = 1'b1;
    mT = 0;
    popped[mG] = 0;
    mW = wordsOf(mPkt.len);
    mLenBad = (int'(mPkt.len) < 8) || (int'(mPkt.len) > MAXLEN);
    if (obsReqT < 0) obsReqT = cyc;
    if (mLenBad) begin
      mDoneT = 2; mStatus = 2'b10;
    end else if (mPkt.stall >= 0 && mPkt.stall < mW) begin
      mDoneT = 4 + mPkt.stall; mStatus = 2'b11;
    end else if (mPkt.finT >= 3 && mPkt.finT <= 2 + mW) begin
      mDoneT = 3 + mW; mStatus = mPkt.ok ? 2'b00 : 2'b01;
    end else if (mPkt.finT >= 3 + mW && mPkt.finT <= 2 + mW + TIMEOUT) begin
      mDoneT = mPkt.finT + 1; mStatus = mPkt.ok ? 2'b00 : 2'b01;
    end else begin
      mDoneT = 3 + mW + TIMEOUT; mStatus = 2'b11;
    end
  endtask

  task automatic applyStimulus();
    pkt_t p;
    if (!mActive && (pending(0) || pending(1))) startPacket();
    req = {pending(1), pending(0)};
    src_ip_in = '0; dest_ip_in = '0; len_udp_in = '0; s_data = '0; s_valid = '0;
    for (int i = 0; i < 2; i++) begin
      if (pending(i)) begin
        p = headPkt(i);
        src_ip_in[i*32 +: 32]  = p.sip;
        dest_ip_in[i*32 +: 32] = p.dip;
        len_udp_in[i*16 +: 16] = p.len;
        s_valid[i]             = (popped[i] < wordsOf(p.len)) && (popped[i] != p.stall);
        s_data[i*32 +: 32]     = wordOf(p, popped[i]);
      end
    end
    dec_fin = mActive && (mT == mPkt.finT);
    dec_ok  = mActive ? mPkt.ok : 1'b0;
  endtask

  task automatic checkOutput();
    logic [1:0]  eGnt, eRd;
    logic        eBusy, eDone, eRst, eStart;
    logic [31:0] eData;
    int          j;
    eGnt = 2'b00; eRd = 2'b00; eBusy = 1'b0; eDone = 1'b0; eRst = 1'b0; eStart = 1'b0; eData = 32'd0;
    if (mActive) begin
      j = mT - 3;
      eBusy = (mT >= 1);
      eGnt  = (mT >= 1) ? (mG ? 2'b10 : 2'b01) : 2'b00;
      if (mT >= 3 && mT < mDoneT && j < mW && j != mPkt.stall) begin
        eRd    = mG ? 2'b10 : 2'b01;
        eData  = wordOf(mPkt, j);
        eStart = (j == 0);
      end
      eRst  = (mT == 2 && !mLenBad) || (mT == mDoneT && mStatus == 2'b11);
      eDone = (mT == mDoneT);
    end
    mRdExp = eRd;
    chk("gnt", 64'(gnt), 64'(eGnt));
    chk("rd", 64'(rd), 64'(eRd));
    chk("busy", 64'(busy), 64'(eBusy));
    chk("pkt_done", 64'(pkt_done), 64'(eDone));
    chk("dec_reset", 64'(dec_reset), 64'(eRst));
    chk("dec_start", 64'(dec_start), 64'(eStart));
    chk("dec_data", 64'(dec_data), 64'(eData));
    if (eDone) begin
      chk("pkt_src", 64'(pkt_src), 64'(mG));
      chk("pkt_status", 64'(pkt_status), 64'(mStatus));
    end
    if (mActive && mT >= 1) begin
      chk("dec_src_ip", 64'(dec_src_ip), 64'(mPkt.sip));
      chk("dec_dest_ip", 64'(dec_dest_ip), 64'(mPkt.dip));
      chk("dec_len_udp", 64'(dec_len_udp), 64'(mPkt.len));
    end
    if (rd != 2'b00) obsRd++;
    if (dec_reset) obsRst++;
    if (dec_start && obsStartT < 0) obsStartT = cyc;
    if (pkt_done) begin
      obsDoneT = cyc;
      obsSrcIp = dec_src_ip;
      srcLog.push_back(int'(pkt_src));
      statusLog.push_back(int'(pkt_status));
    end
  endtask

  task automatic modelAdvance();
    if (mActive) begin
      if (mRdExp != 2'b00) popped[mG]++;
      if (mT == mDoneT) begin
        mLastG = mG;
        if (mG) void'(pq1.pop_front()); else void'(pq0.pop_front());
        popped[mG] = 0;
        mActive = 1'b0;
      end else begin
        mT++;
      end
    end
    cyc++;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput();
    modelAdvance();
  endtask

  task automatic clearObs();
    obsRd = 0; obsRst = 0; obsReqT = -1; obsStartT = -1; obsDoneT = -1; obsSrcIp = 32'd0;
    srcLog.delete();
    statusLog.delete();
  endtask

  task automatic runUntilIdle(input int maxCycles);
    int n;
    n = 0;
    while ((mActive || pending(0) || pending(1)) && n < maxCycles) begin
      stepCycle();
      n++;
    end
    chk("drain_bound", 64'(n < maxCycles), 64'(1));
    stepCycle();
    stepCycle();
  endtask

  // One cycle of reset, then all outputs must sit at their reset values.
  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; req = '0; s_valid = '0; s_data = '0; dec_fin = 1'b0; dec_ok = 1'b0;
    #1;
    chk("rst_dec_reset_high", 64'(dec_reset), 64'(1));
    cyc++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rd", 64'(rd), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pkt_done", 64'(pkt_done), 64'(0));
    chk("rst_pkt_status", 64'(pkt_status), 64'(0));
    chk("rst_pkt_src", 64'(pkt_src), 64'(0));
    chk("rst_dec_start", 64'(dec_start), 64'(0));
    chk("rst_dec_data", 64'(dec_data), 64'(0));
    chk("rst_dec_reset_low", 64'(dec_reset), 64'(0));
    chk("rst_dec_ip_len", {dec_src_ip, dec_dest_ip} | 64'(dec_len_udp), 64'(0));
    pq0.delete();
    pq1.delete();
    mActive = 1'b0; mLastG = 1'b1; popped[0] = 0; popped[1] = 0;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; req = '0; src_ip_in = '0; dest_ip_in = '0; len_udp_in = '0;
    s_data = '0; s_valid = '0; dec_ok = 1'b0; dec_fin = 1'b0;
    popped[0] = 0; popped[1] = 0;
    clearObs();
    doReset();

    // 1: "Hello World", 19 bytes = 5 words, fin on the first WAIT_FIN cycle with ok.
    $display("[TB] test 1: single hello packet on q0");
    clearObs();
    pq0.push_back(mkPkt(19, 32'h9801331b, 32'h980e5e4b, -1, 8, 1'b1, 1'b1));
    runUntilIdle(200);
    chk("t1_rd_count", 64'(obsRd), 64'(5));
    chk("t1_start_latency", 64'(obsStartT - obsReqT), 64'(3));
    chk("t1_start_to_done", 64'(obsDoneT - obsStartT), 64'(6));
    chk("t1_done_count", 64'(srcLog.size()), 64'(1));
    chk("t1_src", 64'(srcLog[0]), 64'(0));
    chk("t1_status", 64'(statusLog[0]), 64'(0));
    chk("t1_src_ip", 64'(obsSrcIp), 64'(32'h9801331b));

    // 2: both queues loaded after reset, served 0,1,0,1.
    $display("[TB] test 2: round robin");
    doReset();
    clearObs();
    pq0.push_back(mkPkt(12, 32'h0a000001, 32'h0a0000f1, -1, 7, 1'b1, 1'b0));
    pq0.push_back(mkPkt(16, 32'h0a000002, 32'h0a0000f2, -1, 8, 1'b0, 1'b0));
    pq1.push_back(mkPkt(24, 32'h0b000001, 32'h0b0000f1, -1, 10, 1'b1, 1'b0));
    pq1.push_back(mkPkt(10, 32'h0b000002, 32'h0b0000f2, -1, 7, 1'b0, 1'b0));
    runUntilIdle(400);
    chk("t2_done_count", 64'(srcLog.size()), 64'(4));
    if (srcLog.size() == 4) begin
      chk("t2_order", 64'({srcLog[0][0], srcLog[1][0], srcLog[2][0], srcLog[3][0]}), 64'(4'b0101));
      chk("t2_status", 64'({statusLog[0][1:0], statusLog[1][1:0], statusLog[2][1:0], statusLog[3][1:0]}),
          64'(8'b00_00_01_01));
    end

    // 3: bad lengths are rejected without touching the decoder or the queue.
    $display("[TB] test 3: length bounds");
    clearObs();
    pq0.push_back(mkPkt(7, 32'h0c000001, 32'h0c0000f1, -1, -1, 1'b1, 1'b0));
    pq0.push_back(mkPkt(1481, 32'h0c000002, 32'h0c0000f2, -1, -1, 1'b1, 1'b0));
    runUntilIdle(50);
    chk("t3_rd_count", 64'(obsRd), 64'(0));
    chk("t3_dec_reset_count", 64'(obsRst), 64'(0));
    chk("t3_done_count", 64'(statusLog.size()), 64'(2));
    if (statusLog.size() == 2) chk("t3_status", 64'({statusLog[0][1:0], statusLog[1][1:0]}), 64'(4'b1010));
    clearObs();
    pq0.push_back(mkPkt(8, 32'h0c000003, 32'h0c0000f3, -1, 5, 1'b0, 1'b0));
    pq0.push_back(mkPkt(1480, 32'h0c000004, 32'h0c0000f4, -1, 373, 1'b1, 1'b0));
    runUntilIdle(1000);
    chk("t3b_rd_count", 64'(obsRd), 64'(372));
    if (statusLog.size() == 2) chk("t3b_status", 64'({statusLog[0][1:0], statusLog[1][1:0]}), 64'(4'b0100));
    else chk("t3b_done_count", 64'(statusLog.size()), 64'(2));

    // 4: queue underruns at word 3 of 5.
    $display("[TB] test 4: underrun");
    clearObs();
    pq0.push_back(mkPkt(20, 32'h0d000001, 32'h0d0000f1, 3, -1, 1'b1, 1'b0));
    runUntilIdle(100);
    chk("t4_rd_count", 64'(obsRd), 64'(3));
    chk("t4_dec_reset_count", 64'(obsRst), 64'(2));
    if (statusLog.size() == 1) chk("t4_status", 64'(statusLog[0]), 64'(3));
    else chk("t4_done_count", 64'(statusLog.size()), 64'(1));

    // 5: timeout after 64 WAIT_FIN cycles, fin on cycle 64 (ok and not ok), fin mid-stream.
    $display("[TB] test 5: fin timing");
    clearObs();
    pq1.push_back(mkPkt(19, 32'h0e000001, 32'h0e0000f1, -1, -1, 1'b1, 1'b0));
    runUntilIdle(200);
    chk("t5a_start_to_done", 64'(obsDoneT - obsStartT), 64'(69));
    if (statusLog.size() == 1) chk("t5a_status", 64'(statusLog[0]), 64'(3));
    clearObs();
    pq1.push_back(mkPkt(19, 32'h0e000002, 32'h0e0000f2, -1, 71, 1'b0, 1'b0));
    runUntilIdle(200);
    chk("t5b_start_to_done", 64'(obsDoneT - obsStartT), 64'(69));
    if (statusLog.size() == 1) chk("t5b_status", 64'(statusLog[0]), 64'(1));
    clearObs();
    pq1.push_back(mkPkt(19, 32'h0e000003, 32'h0e0000f3, -1, 71, 1'b1, 1'b0));
    runUntilIdle(200);
    if (statusLog.size() == 1) chk("t5c_status", 64'(statusLog[0]), 64'(0));
    else chk("t5c_done_count", 64'(statusLog.size()), 64'(1));
    clearObs();
    pq1.push_back(mkPkt(19, 32'h0e000004, 32'h0e0000f4, -1, 5, 1'b1, 1'b0));
    runUntilIdle(100);
    chk("t5d_start_to_done", 64'(obsDoneT - obsStartT), 64'(5));
    chk("t5d_rd_count", 64'(obsRd), 64'(5));

    // 6: reset in the middle of streaming, then q0 must win the next tie.
    $display("[TB] test 6: reset mid-stream");
    clearObs();
    pq0.push_back(mkPkt(40, 32'h0f000001, 32'h0f0000f1, -1, -1, 1'b1, 1'b0));
    n = 0;
    while (!(mActive && mT == 5) && n < 20) begin
      stepCycle();
      n++;
    end
    chk("t6_reach_stream", 64'(n < 20), 64'(1));
    doReset();
    chk("t6_no_done", 64'(srcLog.size()), 64'(0));
    pq0.push_back(mkPkt(12, 32'h0f000002, 32'h0f0000f2, -1, 7, 1'b1, 1'b0));
    pq1.push_back(mkPkt(12, 32'h0f000003, 32'h0f0000f3, -1, 7, 1'b0, 1'b0));
    runUntilIdle(200);
    chk("t6_done_count", 64'(srcLog.size()), 64'(2));
    if (srcLog.size() == 2) chk("t6_first_src", 64'(srcLog[0]), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
